// File: rtl/pyhdl_via_event_tx.sv
// Event FIFO serialised into HDR/DATA frames for the listener side.
// Define PYHDL_IF_VIA_EVENT_TS_EN to append a cycle-count TS word.
module pyhdl_via_event_tx #(
  parameter int DEPTH        = 8,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       ev_valid,
  output logic                       ev_ready,
  input  logic [3:0]                 ev_kind,
  input  logic [15:0]                ev_id,
  input  logic [31:0]                ev_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                drop_count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]  kind;
    logic [11:0] seq;
    logic [15:0] id;
    logic [31:0] data;
`ifdef PYHDL_IF_VIA_EVENT_TS_EN
    logic [31:0] ts;
`endif
  } entry_t;

`ifdef PYHDL_IF_VIA_EVENT_TS_EN
  typedef enum logic [1:0] {IDLE, HDR, DATA, TS} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

  state_t        state, state_n;
  entry_t        mem [DEPTH];
  entry_t        head, wr_entry;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [11:0]   seq;
  logic          full, empty, push, pop, drop, more;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign ev_ready = (DROP_ON_FULL != 0) ? 1'b1 : !full;
  assign push     = ev_valid && !full;
  assign drop     = ev_valid && full && (DROP_ON_FULL != 0);
  assign level    = count;
  assign head     = mem[rd_ptr];
  // a follow-on frame exists if anything stays after this pop
  assign more     = (count > (AW+1)'(1)) || push;

`ifdef PYHDL_IF_VIA_EVENT_TS_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 32'd1;
  end

  assign wr_entry = '{kind: ev_kind, seq: seq, id: ev_id,
                      data: ev_data, ts: ts_cnt};
`else
  assign wr_entry = '{kind: ev_kind, seq: seq, id: ev_id,
                      data: ev_data};
`endif

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      seq        <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push || drop) seq <= seq + 12'd1;
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    unique case (state)
      IDLE: if (!empty) state_n = HDR;
      HDR: begin
        out_valid = 1'b1;
        out_data  = {head.kind, head.seq, head.id};
        if (out_ready) state_n = DATA;
      end
      DATA: begin
        out_valid = 1'b1;
        out_data  = head.data;
`ifdef PYHDL_IF_VIA_EVENT_TS_EN
        if (out_ready) state_n = TS;
`else
        out_last  = 1'b1;
        if (out_ready) begin
          pop     = 1'b1;
          state_n = more ? HDR : IDLE;
        end
`endif
      end
`ifdef PYHDL_IF_VIA_EVENT_TS_EN
      TS: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = head.ts;
        if (out_ready) begin
          pop     = 1'b1;
          state_n = more ? HDR : IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pyhdl_via_event_tx.sv
// Bench for pyhdl_via_event_tx: back-pressure and drop-on-full instances.
// Define PYHDL_IF_VIA_EVENT_TS_EN to exercise the timestamp word.
module tb_pyhdl_via_event_tx;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        sel = 1'b0;
  logic        ev_v = 1'b0;
  logic        ordy = 1'b0;
  logic [3:0]  ev_kind = '0;
  logic [15:0] ev_id = '0;
  logic [31:0] ev_data = '0;

  logic        rdy_bp, ov_bp, last_bp;
  logic [31:0] od_bp;
  logic [3:0]  lvl_bp;
  logic [15:0] dc_bp;
  logic        rdy_dr, ov_dr, last_dr;
  logic [31:0] od_dr;
  logic [3:0]  lvl_dr;
  logic [15:0] dc_dr;

  pyhdl_via_event_tx #(.DEPTH(8), .DROP_ON_FULL(0)) u_bp (
    .clock(clock), .reset_n(reset_n),
    .ev_valid(ev_v && !sel), .ev_ready(rdy_bp),
    .ev_kind(ev_kind), .ev_id(ev_id), .ev_data(ev_data),
    .out_valid(ov_bp), .out_ready(ordy && !sel),
    .out_data(od_bp), .out_last(last_bp),
    .level(lvl_bp), .drop_count(dc_bp)
  );

  pyhdl_via_event_tx #(.DEPTH(8), .DROP_ON_FULL(1)) u_dr (
    .clock(clock), .reset_n(reset_n),
    .ev_valid(ev_v && sel), .ev_ready(rdy_dr),
    .ev_kind(ev_kind), .ev_id(ev_id), .ev_data(ev_data),
    .out_valid(ov_dr), .out_ready(ordy && sel),
    .out_data(od_dr), .out_last(last_dr),
    .level(lvl_dr), .drop_count(dc_dr)
  );

  wire        rdy_m  = sel ? rdy_dr  : rdy_bp;
  wire        ov_m   = sel ? ov_dr   : ov_bp;
  wire        last_m = sel ? last_dr : last_bp;
  wire [31:0] od_m   = sel ? od_dr   : od_bp;
  wire [3:0]  lvl_m  = sel ? lvl_dr  : lvl_bp;
  wire [15:0] dc_m   = sel ? dc_dr   : dc_bp;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  typedef struct {
    logic [3:0]  kind;
    logic [15:0] id;
    logic [31:0] data;
    logic [31:0] hdr;
  } vec_t;

  word_t       exp_q[$];
  int          nvec = 0;
  int          nfail = 0;
  logic [11:0] mseq = '0;
  logic [31:0] bcnt = '0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) bcnt <= '0;
    else          bcnt <= bcnt + 32'd1;
  end

  always @(negedge clock) begin
    word_t e;
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        nvec++;
        if (!ov_m || od_m !== prev_data || last_m !== prev_last) begin
          nfail++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   ov_m, od_m, last_m, prev_data, prev_last);
        end
      end
      if (ov_m && ordy) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL extra_word: got %h, want none", od_m);
        end else begin
          e = exp_q.pop_front();
          if (od_m !== e.data || last_m !== e.last) begin
            nfail++;
            $display("FAIL word: got %h last=%b want %h last=%b",
                     od_m, last_m, e.data, e.last);
          end
        end
      end
      stall_prev = ov_m && !ordy;
      prev_data  = od_m;
      prev_last  = last_m;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic do_reset();
    ev_v = 1'b0;
    ordy = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    exp_q.delete();
    mseq = '0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] k, input logic [15:0] i,
                      input logic [31:0] d, input bit take,
                      input logic [31:0] hdr);
    int t;
    ev_kind = k;
    ev_id   = i;
    ev_data = d;
    ev_v    = 1'b1;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!rdy_m && t < 200);
    if (!rdy_m) begin
      nvec++;
      nfail++;
      $display("FAIL send_timeout: got ev_ready=0 want 1");
    end else begin
      if (take) begin
        exp_q.push_back('{hdr, 1'b0});
`ifdef PYHDL_IF_VIA_EVENT_TS_EN
        exp_q.push_back('{d, 1'b0});
        exp_q.push_back('{bcnt, 1'b1});
`else
        exp_q.push_back('{d, 1'b1});
`endif
      end
      mseq++;
    end
    @(posedge clock);
    #1;
    ev_v = 1'b0;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clock);
      t++;
    end
    @(posedge clock);
    #1;
    if (exp_q.size() != 0) begin
      nvec++;
      nfail++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  vec_t vt[4];

  initial begin
    vt[0] = '{4'h3, 16'h0042, 32'hDEADBEEF, 32'h30000042};
    vt[1] = '{4'hF, 16'hFFFF, 32'h00000000, 32'hF001FFFF};
    vt[2] = '{4'h0, 16'h0000, 32'hFFFFFFFF, 32'h00020000};
    vt[3] = '{4'hA, 16'h1234, 32'h5555AAAA, 32'hA0031234};

    #3;
    chk("rst_ov_bp",   {31'd0, ov_bp},   32'd0);
    chk("rst_od_bp",   od_bp,            32'd0);
    chk("rst_last_bp", {31'd0, last_bp}, 32'd0);
    chk("rst_lvl_bp",  {28'd0, lvl_bp},  32'd0);
    chk("rst_rdy_bp",  {31'd0, rdy_bp},  32'd1);
    chk("rst_dc_dr",   {16'd0, dc_dr},   32'd0);
    chk("rst_rdy_dr",  {31'd0, rdy_dr},  32'd1);

    // single frames, listener always ready
    sel = 1'b0;
    do_reset();
    ordy = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send(vt[v].kind, vt[v].id, vt[v].data, 1'b1, vt[v].hdr);
      wait_empty();
    end
    chk("lvl_after_vec", {28'd0, lvl_m}, 32'd0);

    // fill to full with back-pressure, then drain gap-free
    do_reset();
    for (int n = 0; n < 8; n++)
      send(4'(n), 16'(16'h100 + n), 32'(32'hC0DE0000 + n), 1'b1,
           {4'(n), mseq, 16'(16'h100 + n)});
    @(negedge clock);
    chk("full_level", {28'd0, lvl_m}, 32'd8);
    chk("full_ready", {31'd0, rdy_m}, 32'd0);
    ev_v = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    ev_v = 1'b0;
    chk("full_hold", {28'd0, lvl_m}, 32'd8);
    ordy = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clock);
      chk("no_gap", {31'd0, ov_m}, 32'd1);
      if (j == 1) chk("no_credit", {31'd0, rdy_m}, 32'd0);
      if (j == 2) begin
        chk("pop_ready", {31'd0, rdy_m}, 32'd1);
        chk("pop_level", {28'd0, lvl_m}, 32'd7);
      end
    end
    wait_empty();
    chk("drained_lvl", {28'd0, lvl_m}, 32'd0);

    // drop-on-full: 10 events into 8 entries
    sel = 1'b1;
    do_reset();
    for (int n = 0; n < 10; n++)
      send(4'h5, 16'(n), 32'(n), n < 8, {4'h5, mseq, 16'(n)});
    @(negedge clock);
    chk("drop_cnt",   {16'd0, dc_m},    32'd2);
    chk("drop_level", {28'd0, lvl_m},   32'd8);
    chk("drop_ready", {31'd0, rdy_m},   32'd1);
    @(posedge clock);
    #1;
    ordy = 1'b1;
    wait_empty();
    send(4'h6, 16'hBEEF, 32'h0A0A0A0A, 1'b1, 32'h600ABEEF);
    wait_empty();

    // seq wrap: 4096 presented events, 8 kept
    do_reset();
    for (int n = 0; n < 4096; n++)
      send(4'h1, 16'h0, 32'(n), n < 8, {4'h1, mseq, 16'h0});
    @(negedge clock);
    chk("wrap_drops", {16'd0, dc_m}, 32'd4088);
    @(posedge clock);
    #1;
    ordy = 1'b1;
    wait_empty();
    send(4'h2, 16'h0777, 32'h12345678, 1'b1, 32'h20000777);
    wait_empty();

    // listener stalls every other cycle
    sel = 1'b0;
    do_reset();
    fork
      begin
        send(4'h7, 16'hAAAA, 32'h11111111, 1'b1, {4'h7, mseq, 16'hAAAA});
        send(4'h8, 16'h5555, 32'h22222222, 1'b1, {4'h8, mseq, 16'h5555});
        send(4'h9, 16'h0F0F, 32'h33333333, 1'b1, {4'h9, mseq, 16'h0F0F});
      end
      begin
        for (int c = 0; c < 24; c++) begin
          ordy = ~ordy;
          @(posedge clock);
          #1;
        end
        ordy = 1'b1;
      end
    join
    wait_empty();

    // reset mid-frame after the HDR word
    do_reset();
    ordy = 1'b1;
    send(4'hC, 16'h00C0, 32'hCAFEF00D, 1'b1, {4'hC, mseq, 16'h00C0});
    begin
      int t;
      t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (!(ov_m && ordy) && t < 50);
      chk("hdr_seen", {31'd0, ov_m}, 32'd1);
    end
    @(posedge clock);
    #1;
    ordy = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ov",  {31'd0, ov_m},  32'd0);
    chk("mid_rst_lvl", {28'd0, lvl_m}, 32'd0);
    chk("mid_rst_rdy", {31'd0, rdy_m}, 32'd1);
    exp_q.delete();
    mseq = '0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    ordy = 1'b1;
    send(4'hD, 16'h0001, 32'h0BADC0DE, 1'b1, 32'hD0000001);
    wait_empty();

`ifdef PYHDL_IF_VIA_EVENT_TS_EN
    // event taken on the 5th edge after release carries TS 4
    do_reset();
    repeat (3) @(posedge clock);
    #1;
    ordy = 1'b1;
    send(4'h4, 16'h0044, 32'h44444444, 1'b1, 32'h40000044);
    begin
      int t;
      t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (!(ov_m && last_m) && t < 50);
      chk("ts_word", od_m, 32'd4);
    end
    wait_empty();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
